// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - master-side and controller-side signal bundle for sdram_arbiter
interface sdram_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]    m_request;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [26*NUM_MASTERS-1:0] m_address;
  logic [32*NUM_MASTERS-1:0] m_wdata;
  logic [4*NUM_MASTERS-1:0]  m_byte_en;
  logic [NUM_MASTERS-1:0]    m_burst;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_rvalid;
  logic [31:0]               m_rdata;
  logic [NUM_MASTERS-1:0]    m_complete;

  logic        sdram_request;
  logic [3:0]  sdram_master;
  logic        sdram_write;
  logic [25:0] sdram_address;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_byte_en;
  logic        sdram_burst;
  logic [31:0] sdram_rdata;
  logic [3:0]  sdram_valid;
  logic [3:0]  sdram_complete;
  logic        sdram_ready;

  modport slave (
    input  m_request, m_write, m_address, m_wdata, m_byte_en, m_burst,
    output m_ack, m_rvalid, m_rdata, m_complete,
    output sdram_request, sdram_master, sdram_write, sdram_address,
    output sdram_wdata, sdram_byte_en, sdram_burst,
    input  sdram_rdata, sdram_valid, sdram_complete, sdram_ready
  );

  modport master (
    output m_request, m_write, m_address, m_wdata, m_byte_en, m_burst,
    input  m_ack, m_rvalid, m_rdata, m_complete,
    input  sdram_request, sdram_master, sdram_write, sdram_address,
    input  sdram_wdata, sdram_byte_en, sdram_burst,
    output sdram_rdata, sdram_valid, sdram_complete, sdram_ready
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin multi-master front end for the SDRAM controller
// Define SDRAM_ARB_PRIORITY_EN to give master index 0 absolute priority when arbitrating.
module sdram_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic           clock,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);
  typedef enum logic {ARB, GRANT} state_t;

  state_t      state_q;
  logic [3:0]  grant_q;
  logic [3:0]  last_grant_q;
  logic [3:0]  master_q;
  logic        request_q;
  logic [31:0] wdata_hold_q;
  logic [3:0]  be_hold_q;

  logic [3:0]             pick;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] sel;
  logic                   accept;
  logic [25:0]            mux_address;
  logic [31:0]            mux_wdata;
  logic [3:0]             mux_be;
  logic                   mux_write;
  logic                   mux_burst;

  always_comb begin : pick_next
    int idx;
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!any_req && |(bus.m_request & (NUM_MASTERS'(1) << idx))) begin
        any_req = 1'b1;
        pick    = 4'(idx);
      end
    end
`ifdef SDRAM_ARB_PRIORITY_EN
    if (bus.m_request[0]) begin
      any_req = 1'b1;
      pick    = '0;
    end
`endif
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) sel[k] = (grant_q == 4'(k));
  end

  assign mux_address = 26'(bus.m_address >> (int'(grant_q) * 26));
  assign mux_wdata   = 32'(bus.m_wdata >> (int'(grant_q) * 32));
  assign mux_be      = 4'(bus.m_byte_en >> (int'(grant_q) * 4));
  assign mux_write   = |(bus.m_write & sel);
  assign mux_burst   = |(bus.m_burst & sel);
  assign accept      = (state_q == GRANT) && bus.sdram_ready;

  assign bus.sdram_request = request_q;
  assign bus.sdram_master  = master_q;
  assign bus.sdram_write   = mux_write;
  assign bus.sdram_address = mux_address;
  assign bus.sdram_burst   = mux_burst;
  // The controller samples the upper halfword a cycle after acceptance, so
  // outside GRANT the last accepted data is replayed from the hold registers.
  assign bus.sdram_wdata   = (state_q == GRANT) ? mux_wdata : wdata_hold_q;
  assign bus.sdram_byte_en = (state_q == GRANT) ? mux_be : be_hold_q;
  assign bus.m_rdata       = bus.sdram_rdata;
  assign bus.m_ack         = accept ? sel : '0;

  always_comb begin
    bus.m_rvalid   = '0;
    bus.m_complete = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      bus.m_rvalid[k]   = (bus.sdram_valid == 4'(k + 1));
      bus.m_complete[k] = (bus.sdram_complete == 4'(k + 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= 4'(NUM_MASTERS - 1);
      master_q     <= '0;
      request_q    <= 1'b0;
      wdata_hold_q <= '0;
      be_hold_q    <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (any_req) begin
            state_q   <= GRANT;
            grant_q   <= pick;
            request_q <= 1'b1;
            master_q  <= pick + 4'd1;
          end
        end
        GRANT: begin
          // Once granted, a master keeps the port until the controller takes it.
          if (bus.sdram_ready) begin
            state_q      <= ARB;
            last_grant_q <= grant_q;
            request_q    <= 1'b0;
            master_q     <= '0;
            wdata_hold_q <= mux_wdata;
            be_hold_q    <= mux_be;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rv0_cnt = 0;
  int   cmp0_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sdram_arbiter_if #(.NUM_MASTERS(N)) bus();

  sdram_arbiter #(.NUM_MASTERS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  num;
    logic [25:0] addr;
    logic        wr;
  } ack_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } rd_t;

  ack_t       ack_q[$];
  rd_t        rd_q[$];
  logic [3:0] cmp_q[$];
  ack_t       ae;
  rd_t        re;
  logic [3:0] ce;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: compare whenever the DUT presents a pulse.
  always @(negedge clock) begin
    if (bus.m_ack != '0) begin
      if (ack_q.size() == 0) check("unexpected_ack", 64'(bus.m_ack), 64'h0);
      else begin
        ae = ack_q.pop_front();
        check("ack_mask", 64'(bus.m_ack), 64'(ae.mask));
        check("ack_master", 64'(bus.sdram_master), 64'(ae.num));
        check("ack_addr", 64'(bus.sdram_address), 64'(ae.addr));
        check("ack_write", 64'(bus.sdram_write), 64'(ae.wr));
      end
    end
    if (bus.m_rvalid != '0) begin
      if (bus.m_rvalid[0]) rv0_cnt++;
      if (rd_q.size() == 0) check("unexpected_rvalid", 64'(bus.m_rvalid), 64'h0);
      else begin
        re = rd_q.pop_front();
        check("rvalid_mask", 64'(bus.m_rvalid), 64'(re.mask));
        check("rdata", 64'(bus.m_rdata), 64'(re.data));
      end
    end
    if (bus.m_complete != '0) begin
      if (bus.m_complete[0]) cmp0_cnt++;
      if (cmp_q.size() == 0) check("unexpected_complete", 64'(bus.m_complete), 64'h0);
      else begin
        ce = cmp_q.pop_front();
        check("complete_mask", 64'(bus.m_complete), 64'(ce));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_master(input int i, input logic wr, input logic [25:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic bu);
    bus.m_write[i]          = wr;
    bus.m_address[i*26 +: 26] = a;
    bus.m_wdata[i*32 +: 32]   = d;
    bus.m_byte_en[i*4 +: 4]   = be;
    bus.m_burst[i]          = bu;
  endtask

  task automatic expect_ack(input int i);
    ack_t e;
    e.mask = 4'(1 << i);
    e.num  = 4'(i + 1);
    e.addr = bus.m_address[i*26 +: 26];
    e.wr   = bus.m_write[i];
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input int i, input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.m_ack[i]) return;
    end
    check({name, "_ack_timeout"}, 64'(bus.m_ack[i]), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_order[5];
    int prev;
    int first;
    int second;

    reset              = 1'b1;
    bus.m_request      = '0;
    bus.m_write        = '0;
    bus.m_address      = '0;
    bus.m_wdata        = '0;
    bus.m_byte_en      = '0;
    bus.m_burst        = '0;
    bus.sdram_rdata    = 32'hA5A5_0001;
    bus.sdram_valid    = '0;
    bus.sdram_complete = '0;
    bus.sdram_ready    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_request", 64'(bus.sdram_request), 64'h0);
    check("rst_master", 64'(bus.sdram_master), 64'h0);
    check("rst_ack", 64'(bus.m_ack), 64'h0);
    check("rst_rvalid", 64'(bus.m_rvalid), 64'h0);
    check("rst_complete", 64'(bus.m_complete), 64'h0);
    check("rst_rdata_pass", 64'(bus.m_rdata), 64'hA5A5_0001);
    check("rst_wdata_hold", 64'(bus.sdram_wdata), 64'h0);
    check("rst_be_hold", 64'(bus.sdram_byte_en), 64'h0);
    tick();
    reset = 1'b0;

    // Round-robin with all masters requesting continuously.
`ifdef SDRAM_ARB_PRIORITY_EN
    rr_order = '{0, 0, 0, 0, 0};
`else
    rr_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < N; i++) set_master(i, 1'b0, 26'h1000 + 26'(i * 64), 32'h100 + 32'(i), 4'hF, 1'b0);
    foreach (rr_order[g]) expect_ack(rr_order[g]);
    bus.m_request = 4'hF;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      for (int n = 0; n < 40; n++) begin
        @(negedge clock);
        if (bus.m_ack != '0) break;
      end
      check("rr_ack_seen", 64'(bus.m_ack != '0), 64'h1);
      if (g > 0) check("rr_spacing", 64'(cyc - prev), 64'h2);
      prev = cyc;
    end
    tick();
    bus.m_request = '0;

    // Single read from master index 1.
    set_master(1, 1'b0, 26'h0000100, 32'h0, 4'hF, 1'b0);
    expect_ack(1);
    bus.m_request[1] = 1'b1;
    tick();
    check("read_request", 64'(bus.sdram_request), 64'h1);
    check("read_master", 64'(bus.sdram_master), 64'h2);
    wait_ack(1, "read");
    tick();
    bus.m_request[1] = 1'b0;
    bus.sdram_valid  = 4'd2;
    bus.sdram_rdata  = 32'hDEAD_BEEF;
    rd_q.push_back('{mask: 4'b0010, data: 32'hDEAD_BEEF});
    @(negedge clock);
    check("read_rvalid", 64'(bus.m_rvalid), 64'h2);
    check("read_rdata", 64'(bus.m_rdata), 64'hDEAD_BEEF);
    tick();
    bus.sdram_valid = '0;

    // Write hold: upper halfword and byte enables survive past acceptance.
    set_master(1, 1'b1, 26'h0000200, 32'h1234_5678, 4'hF, 1'b0);
    expect_ack(1);
    bus.m_request[1] = 1'b1;
    wait_ack(1, "write");
    tick();
    bus.m_request[1] = 1'b0;
    set_master(1, 1'b1, 26'h0000200, 32'h0, 4'h0, 1'b0);
    @(negedge clock);
    check("hold_wdata_hi", 64'(bus.sdram_wdata[31:16]), 64'h1234);
    check("hold_be_hi", 64'(bus.sdram_byte_en[3:2]), 64'h3);

    // Stall: ready low for 6 cycles while master index 2 is granted.
    tick();
    bus.sdram_ready = 1'b0;
    set_master(2, 1'b1, 26'h0ABCDE0, 32'hCAFE_F00D, 4'h3, 1'b0);
    expect_ack(2);
    bus.m_request[2] = 1'b1;
    tick();
    repeat (6) begin
      @(negedge clock);
      check("stall_ctl", 64'({bus.sdram_request, bus.sdram_master, bus.sdram_write, bus.m_ack,
                              bus.sdram_byte_en, bus.sdram_address}),
            64'({1'b1, 4'd3, 1'b1, 4'd0, 4'h3, 26'h0ABCDE0}));
      check("stall_wdata", 64'(bus.sdram_wdata), 64'hCAFE_F00D);
    end
    tick();
    bus.sdram_ready = 1'b1;
    wait_ack(2, "stall");
    tick();
    bus.m_request[2] = 1'b0;

    // Burst return to master index 0 overlapped by a grant to index 1.
    set_master(0, 1'b0, 26'h0010000, 32'h0, 4'hF, 1'b1);
    expect_ack(0);
    bus.m_request[0] = 1'b1;
    wait_ack(0, "burst");
    tick();
    bus.m_request[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          bus.sdram_valid = 4'd1;
          bus.sdram_rdata = 32'h0000_1000 + 32'(i);
          rd_q.push_back('{mask: 4'b0001, data: 32'h0000_1000 + 32'(i)});
          tick();
          bus.sdram_valid = '0;
          tick();
        end
        bus.sdram_complete = 4'd1;
        cmp_q.push_back(4'b0001);
        tick();
        bus.sdram_complete = '0;
      end
      begin
        tick();
        set_master(1, 1'b1, 26'h0020000, 32'h5555_AAAA, 4'hF, 1'b0);
        expect_ack(1);
        bus.m_request[1] = 1'b1;
        wait_ack(1, "overlap");
        tick();
        bus.m_request[1] = 1'b0;
      end
    join
    check("burst_rvalid_count", 64'(rv0_cnt), 64'h8);
    check("burst_complete_count", 64'(cmp0_cnt), 64'h1);

    // Master numbers beyond NUM_MASTERS are dropped.
    bus.sdram_valid    = 4'd5;
    bus.sdram_complete = 4'd6;
    @(negedge clock);
    check("ignore_high_numbers", 64'({bus.m_rvalid, bus.m_complete}), 64'h0);
    tick();
    bus.sdram_valid    = '0;
    bus.sdram_complete = '0;

    // Priority: last grant index 0, then indices 0 and 2 request together.
    set_master(0, 1'b0, 26'h0030000, 32'h0, 4'hF, 1'b0);
    expect_ack(0);
    bus.m_request[0] = 1'b1;
    wait_ack(0, "prio_setup");
    tick();
    set_master(2, 1'b0, 26'h0040000, 32'h0, 4'hF, 1'b0);
    bus.m_request = 4'b0101;
`ifdef SDRAM_ARB_PRIORITY_EN
    first  = 0;
    second = 2;
`else
    first  = 2;
    second = 0;
`endif
    expect_ack(first);
    expect_ack(second);
    wait_ack(first, "prio_first");
    check("prio_first_master", 64'(bus.sdram_master), 64'(first + 1));
    tick();
    bus.m_request[first] = 1'b0;
    wait_ack(second, "prio_second");
    check("prio_second_master", 64'(bus.sdram_master), 64'(second + 1));
    tick();
    bus.m_request[second] = 1'b0;

    // Reset while granted: request drops, no acknowledge.
    bus.sdram_ready = 1'b0;
    set_master(3, 1'b0, 26'h0050000, 32'h0, 4'hF, 1'b0);
    bus.m_request[3] = 1'b1;
    tick();
    @(negedge clock);
    check("rst_mid_pre_request", 64'(bus.sdram_request), 64'h1);
    tick();
    reset         = 1'b1;
    bus.m_request = '0;
    tick();
    @(negedge clock);
    check("rst_mid_request_drop", 64'(bus.sdram_request), 64'h0);
    check("rst_mid_no_ack", 64'(bus.m_ack), 64'h0);
    tick();
    reset           = 1'b0;
    bus.sdram_ready = 1'b1;
    tick();

    check("ack_queue_drained", 64'(ack_q.size()), 64'h0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'h0);
    check("cmp_queue_drained", 64'(cmp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
